demux_frame_router: RTL and testbench

Upstream control stage for the 1-to-4 demux: the 4-output demux_beh stage.
- Receives a serial frame stream: a 2-bit channel header, MSB first, then PAYLOAD_LEN data bits.
- Drives the demux select and data input for the payload bits, one bit per accepted input bit.
- Also handles per-channel enable masking, inactivity timeout and frame abort, so the demux only ever sees valid routed payload.

---
 rtl/demux_frame_router_if.sv | 25 ++
 rtl/demux_frame_router.sv | 148 ++++++++++++++
 tb/tb_demux_frame_router.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/demux_frame_router_if.sv
// Handshake bundle between the serial frame source, the router and the 1-to-4 demux stage.
// The master side drives the frame stream; the slave side is the router itself.
interface demux_frame_router_if;
    logic       start;
    logic       din;
    logic       din_valid;
    logic [3:0] en_mask;
    logic [1:0] s;
    logic       in_bit;
    logic       out_valid;
    logic       busy;
    logic       frame_done;
    logic       frame_drop;
    logic       frame_err;

    modport master (
        output start, din, din_valid, en_mask,
        input  s, in_bit, out_valid, busy, frame_done, frame_drop, frame_err
    );

    modport slave (
        input  start, din, din_valid, en_mask,
        output s, in_bit, out_valid, busy, frame_done, frame_drop, frame_err
    );
endinterface

// File: rtl/demux_frame_router.sv
// Frame router ahead of the 1-to-4 demux: captures a 2-bit channel header, then forwards
// payload bits with a registered select, with channel masking, inactivity timeout and abort.
module demux_frame_router #(
    parameter int PAYLOAD_LEN = 8,
    parameter int TIMEOUT     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    demux_frame_router_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    localparam logic [7:0] PAY_LAST  = 8'(PAYLOAD_LEN - 1);
    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       hdr_cnt_q, hdr_cnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] sel_new;
    logic       drop_q, drop_d;
    logic [7:0] pay_cnt_q, pay_cnt_d;
    logic [7:0] idle_q, idle_d;

    logic [1:0] s_q, s_d;
    logic       in_bit_q, in_bit_d;
    logic       out_valid_q, out_valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       fdrop_q, fdrop_d;
    logic       err_q, err_d;

    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        sel_d       = sel_q;
        sel_new     = {sel_q[0], bus.din};
        drop_d      = drop_q;
        pay_cnt_d   = pay_cnt_q;
        idle_d      = idle_q;
        s_d         = s_q;
        in_bit_d    = 1'b0;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        fdrop_d     = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = HDR;
                    hdr_cnt_d = 1'b0;
                    pay_cnt_d = 8'd0;
                    idle_d    = 8'd0;
                end
            end
            HDR, PAYLOAD: begin
                // start has priority over timeout and completion; the bit in that cycle is dropped
                if (bus.start) begin
                    err_d     = 1'b1;
                    state_d   = HDR;
                    hdr_cnt_d = 1'b0;
                    pay_cnt_d = 8'd0;
                    idle_d    = 8'd0;
                end else if (!bus.din_valid) begin
                    if (idle_q == IDLE_LAST) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                        idle_d  = 8'd0;
                    end else begin
                        idle_d = idle_q + 8'd1;
                    end
                end else begin
                    idle_d = 8'd0;
                    if (state_q == HDR) begin
                        sel_d = sel_new;
                        if (hdr_cnt_q) begin
                            // channel enable is sampled once here; later mask changes do not matter
                            s_d       = sel_new;
                            drop_d    = ~bus.en_mask[sel_new];
                            state_d   = PAYLOAD;
                            pay_cnt_d = 8'd0;
                        end else begin
                            hdr_cnt_d = 1'b1;
                        end
                    end else begin
                        pay_cnt_d   = pay_cnt_q + 8'd1;
                        out_valid_d = ~drop_q;
                        in_bit_d    = ~drop_q & bus.din;
                        if (pay_cnt_q == PAY_LAST) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            fdrop_d = drop_q;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hdr_cnt_q   <= 1'b0;
            sel_q       <= 2'b00;
            drop_q      <= 1'b0;
            pay_cnt_q   <= 8'd0;
            idle_q      <= 8'd0;
            s_q         <= 2'b00;
            in_bit_q    <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fdrop_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            sel_q       <= sel_d;
            drop_q      <= drop_d;
            pay_cnt_q   <= pay_cnt_d;
            idle_q      <= idle_d;
            s_q         <= s_d;
            in_bit_q    <= in_bit_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fdrop_q     <= fdrop_d;
            err_q       <= err_d;
        end
    end

    assign bus.s          = s_q;
    assign bus.in_bit     = in_bit_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign bus.frame_drop = fdrop_q;
    assign bus.frame_err  = err_q;

endmodule

// File: tb/tb_demux_frame_router.sv
// Directed bench for demux_frame_router: routed, dropped, gapped, timed-out, restarted and reset frames.
module tb_demux_frame_router;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    demux_frame_router_if bus ();

    demux_frame_router #(
        .PAYLOAD_LEN (8),
        .TIMEOUT     (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic st, input logic d, input logic v);
        bus.start     = st;
        bus.din       = d;
        bus.din_valid = v;
        @(posedge clk);
        #1;
    endtask

    // Header plus continuous payload, starting from the HDR state.
    task automatic hdr_and_payload(input logic [1:0] h, input logic [7:0] d, input logic drop,
                                   input logic [3:0] mask_pay, input string tag);
        cyc(1'b0, h[1], 1'b1);
        check({tag, " busy hdr"}, bus.busy, 1'b1);
        cyc(1'b0, h[0], 1'b1);
        check({tag, " s"}, bus.s, h);
        check({tag, " ov hdr"}, bus.out_valid, 1'b0);
        bus.en_mask = mask_pay;
        for (int i = 7; i >= 0; i--) begin
            cyc(1'b0, d[i], 1'b1);
            check({tag, " out_valid"}, bus.out_valid, !drop);
            check({tag, " in_bit"}, bus.in_bit, !drop && d[i]);
            check({tag, " frame_done"}, bus.frame_done, i == 0);
            check({tag, " frame_drop"}, bus.frame_drop, (i == 0) && drop);
            check({tag, " busy"}, bus.busy, i != 0);
            check({tag, " frame_err"}, bus.frame_err, 1'b0);
        end
        cyc(1'b0, 1'b1, 1'b0);
        check({tag, " ov after"}, bus.out_valid, 1'b0);
        check({tag, " in_bit after"}, bus.in_bit, 1'b0);
        check({tag, " done after"}, bus.frame_done, 1'b0);
        check({tag, " s hold"}, bus.s, h);
    endtask

    task automatic send_frame(input logic [1:0] h, input logic [7:0] d, input logic drop,
                              input logic [3:0] mask_pay, input string tag);
        cyc(1'b1, 1'b1, 1'b1);
        check({tag, " busy start"}, bus.busy, 1'b1);
        hdr_and_payload(h, d, drop, mask_pay, tag);
    endtask

    initial begin
        logic [4:0] pat;
        logic [7:0] data;
        logic       v;
        int         acc;

        checks        = 0;
        errors        = 0;
        bus.start     = 1'b0;
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
        bus.en_mask   = 4'b1111;
        rst_n         = 1'b0;
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        check("rst s", bus.s, 2'b00);
        check("rst out_valid", bus.out_valid, 1'b0);
        check("rst in_bit", bus.in_bit, 1'b0);
        check("rst busy", bus.busy, 1'b0);
        check("rst pulses", {bus.frame_done, bus.frame_drop, bus.frame_err}, 3'b000);
        rst_n = 1'b1;

        // din is ignored in IDLE
        cyc(1'b0, 1'b1, 1'b1);
        check("idle busy", bus.busy, 1'b0);
        check("idle ov", bus.out_valid, 1'b0);

        // 1: routed frame to channel 2
        send_frame(2'b10, 8'b10110011, 1'b0, 4'b1111, "t1");

        // 2: channel 1 disabled; enabling it mid-frame must not matter
        bus.en_mask = 4'b1101;
        send_frame(2'b01, 8'b10110011, 1'b1, 4'b1111, "t2");

        // 3: payload with din_valid gaps, channel 0
        pat  = 5'b10110;
        data = 8'b11010010;
        acc  = 0;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        check("t3 s", bus.s, 2'b00);
        for (int k = 0; k < 40 && acc < 8; k++) begin
            v = pat[4 - (k % 5)];
            cyc(1'b0, v ? data[7 - acc] : 1'b1, v);
            check("t3 out_valid", bus.out_valid, v);
            check("t3 in_bit", bus.in_bit, v && data[7 - acc]);
            if (v) acc++;
            check("t3 frame_done", bus.frame_done, v && (acc == 8));
        end
        check("t3 count", 8'(acc), 8'd8);
        cyc(1'b0, 1'b0, 1'b0);
        check("t3 busy end", bus.busy, 1'b0);

        // 4: timeout after 3 payload bits
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        check("t4 s", bus.s, 2'b11);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
        check("t4 ov bit3", bus.out_valid, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            check("t4 frame_err", bus.frame_err, i == 16);
            check("t4 busy", bus.busy, i != 16);
            check("t4 frame_done", bus.frame_done, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0);
        check("t4 err pulse", bus.frame_err, 1'b0);
        send_frame(2'b01, 8'b01100101, 1'b0, 4'b1111, "t4b");

        // 5: start during the 5th payload bit restarts the frame
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        check("t5 frame_err", bus.frame_err, 1'b1);
        check("t5 ov dropped", bus.out_valid, 1'b0);
        check("t5 in_bit", bus.in_bit, 1'b0);
        check("t5 busy", bus.busy, 1'b1);
        check("t5 frame_done", bus.frame_done, 1'b0);
        hdr_and_payload(2'b11, 8'h5A, 1'b0, 4'b1111, "t5");

        // 6: reset mid-payload
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        cyc(1'b0, 1'b1, 1'b1);
        check("t6 s", bus.s, 2'b00);
        check("t6 out_valid", bus.out_valid, 1'b0);
        check("t6 in_bit", bus.in_bit, 1'b0);
        check("t6 busy", bus.busy, 1'b0);
        check("t6 pulses", {bus.frame_done, bus.frame_drop, bus.frame_err}, 3'b000);
        rst_n = 1'b1;
        cyc(1'b0, 1'b1, 1'b1);
        check("t6 no err", bus.frame_err, 1'b0);
        check("t6 idle ov", bus.out_valid, 1'b0);
        send_frame(2'b10, 8'b11100001, 1'b0, 4'b1111, "t6b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
